// File: rtl/store_buffer.sv
// store_buffer
//   Posted-store queue between the MEM-stage store path and the data memory.
//   Committed stores become word-aligned, byte-enabled entries in a small
//   circular FIFO, drained to DM one per cycle while the DM write port is
//   free. Loads get per-byte forwarding from all pending entries.
//
// Ports
//   clk, reset      clock; synchronous active-low reset
//   st_valid/addr/data/type/pc   committed store from MEM
//   st_ready        buffer can take a store (not dependent on drain_en)
//   st_misalign     st_valid with illegal alignment/type (store dropped)
//   drain_en        DM write port free this cycle
//   dm_we/addr/wdata/be/pc       head entry presented to DM
//   ld_addr         MEM load address for forwarding lookup
//   fwd_mask/data   byte lanes supplied by the buffer
//   empty, count    occupancy
module store_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    st_valid,
   input  logic [31:0]             st_addr,
   input  logic [31:0]             st_data,
   input  logic [1:0]              st_type,
   input  logic [31:0]             st_pc,
   output logic                    st_ready,
   output logic                    st_misalign,
   input  logic                    drain_en,
   output logic                    dm_we,
   output logic [31:0]             dm_addr,
   output logic [31:0]             dm_wdata,
   output logic [3:0]              dm_be,
   output logic [31:0]             dm_pc,
   input  logic [31:0]             ld_addr,
   output logic [3:0]              fwd_mask,
   output logic [31:0]             fwd_data,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0] ONE  = (PW+1)'(1);

   typedef logic [PW-1:0] ptr_t;

   logic        ent_valid [DEPTH];
   logic [29:0] ent_addr  [DEPTH];
   logic [31:0] ent_data  [DEPTH];
   logic [3:0]  ent_be    [DEPTH];
   logic [31:0] ent_pc    [DEPTH];

   ptr_t        head;
   ptr_t        tail;
   ptr_t        youngest;
   ptr_t        fidx;

   logic        legal;
   logic [3:0]  new_be;
   logic [31:0] new_data;
   logic        accept;
   logic        merge;

   // Alignment check and lane placement of the incoming store.
   always_comb begin
      legal    = 1'b0;
      new_be   = '0;
      new_data = '0;
      case (st_type)
         2'b00: begin
            legal    = (st_addr[1:0] == 2'b00);
            new_be   = 4'b1111;
            new_data = st_data;
         end
         2'b01: begin
            legal = !st_addr[0];
            if (st_addr[1]) begin
               new_be   = 4'b1100;
               new_data = {st_data[15:0], 16'h0000};
            end else begin
               new_be   = 4'b0011;
               new_data = {16'h0000, st_data[15:0]};
            end
         end
         2'b10: begin
            legal    = 1'b1;
            new_be   = 4'b0001 << st_addr[1:0];
            new_data = {24'h000000, st_data[7:0]} << {st_addr[1:0], 3'b000};
         end
         default: legal = 1'b0;
      endcase
   end

   assign empty       = (count == '0);
   assign st_ready    = reset && (count != FULL);
   assign st_misalign = reset && st_valid && !legal;
   assign dm_we       = reset && !empty && drain_en;

   assign dm_addr  = {ent_addr[head], 2'b00};
   assign dm_wdata = ent_data[head];
   assign dm_be    = ent_be[head];
   assign dm_pc    = ent_pc[head];

   assign youngest = tail - ptr_t'(1);
   assign accept   = st_valid && st_ready && legal;
   // Never merge into the single entry that is leaving this cycle.
   assign merge    = !empty && (ent_addr[youngest] == st_addr[31:2]) &&
                     !((count == ONE) && dm_we);

   always_ff @(posedge clk) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_valid[i] <= 1'b0;
         end
      end else begin
         if (dm_we) begin
            ent_valid[head] <= 1'b0;
            head            <= head + ptr_t'(1);
         end
         if (accept) begin
            if (merge) begin
               ent_be[youngest] <= ent_be[youngest] | new_be;
               for (int unsigned l = 0; l < 4; l++) begin
                  if (new_be[l]) begin
                     ent_data[youngest][8*l +: 8] <= new_data[8*l +: 8];
                  end
               end
            end else begin
               ent_valid[tail] <= 1'b1;
               ent_addr[tail]  <= st_addr[31:2];
               ent_data[tail]  <= new_data;
               ent_be[tail]    <= new_be;
               ent_pc[tail]    <= st_pc;
               tail            <= tail + ptr_t'(1);
            end
         end
         if ((accept && !merge) && !dm_we) begin
            count <= count + ONE;
         end else if (!(accept && !merge) && dm_we) begin
            count <= count - ONE;
         end
      end
   end

   // Walk oldest to youngest so younger matching lanes override older ones.
   always_comb begin
      fwd_mask = '0;
      fwd_data = '0;
      fidx     = '0;
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fidx = head + ptr_t'(i);
            if (ent_valid[fidx] && (ent_addr[fidx] == ld_addr[31:2])) begin
               for (int unsigned l = 0; l < 4; l++) begin
                  if (ent_be[fidx][l]) begin
                     fwd_mask[l]        = 1'b1;
                     fwd_data[8*l +: 8] = ent_data[fidx][8*l +: 8];
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [1:0]  st_type;
   logic [31:0] st_pc;
   logic        st_ready;
   logic        st_misalign;
   logic        drain_en;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_be;
   logic [31:0] dm_pc;
   logic [31:0] ld_addr;
   logic [3:0]  fwd_mask;
   logic [31:0] fwd_data;
   logic        empty;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
      .st_type(st_type), .st_pc(st_pc),
      .st_ready(st_ready), .st_misalign(st_misalign),
      .drain_en(drain_en),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_be(dm_be), .dm_pc(dm_pc),
      .ld_addr(ld_addr), .fwd_mask(fwd_mask), .fwd_data(fwd_data),
      .empty(empty), .count(count)
   );

   always #5 clk = ~clk;

   // Reference model: a list of pending word writes, oldest first.
   typedef struct {
      logic [29:0] word;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] pc;
   } ent_t;

   ent_t q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Size in bytes, legality and lane image of the current store request.
   task automatic shape(output logic ok, output logic [3:0] be, output logic [31:0] data);
      int unsigned size;
      int unsigned lane;
      be   = '0;
      data = '0;
      ok   = 1'b0;
      if (st_type != 2'b11) begin
         size = 4 >> st_type;
         ok   = (st_addr % size) == 0;
         for (int unsigned k = 0; k < size; k++) begin
            lane          = (st_addr % 4) + k;
            be[lane]      = 1'b1;
            data[8*lane +: 8] = 8'((st_data >> (8*k)) & 32'hFF);
         end
      end
   endtask

   // One clock: check combinational outputs at negedge against the model,
   // then advance the model on the rising edge.
   task automatic step();
      logic        ok;
      logic [3:0]  nbe;
      logic [31:0] ndata;
      logic        e_ready, e_mis, e_we, acc, mrg;
      logic [3:0]  e_mask;
      logic [31:0] e_fdata;
      ent_t        e;
      @(negedge clk);
      shape(ok, nbe, ndata);
      e_ready = reset && (q.size() < DEPTH);
      e_mis   = reset && st_valid && !ok;
      e_we    = reset && (q.size() > 0) && drain_en;
      e_mask  = '0;
      e_fdata = '0;
      if (reset) begin
         foreach (q[i]) begin
            if (q[i].word == ld_addr[31:2]) begin
               for (int unsigned l = 0; l < 4; l++) begin
                  if (q[i].be[l]) begin
                     e_mask[l]         = 1'b1;
                     e_fdata[8*l +: 8] = q[i].data[8*l +: 8];
                  end
               end
            end
         end
      end
      chk("st_ready", 32'(st_ready), 32'(e_ready));
      chk("st_misalign", 32'(st_misalign), 32'(e_mis));
      chk("dm_we", 32'(dm_we), 32'(e_we));
      if (e_we) begin
         chk("dm_addr", dm_addr, {q[0].word, 2'b00});
         chk("dm_wdata", dm_wdata, q[0].data);
         chk("dm_be", 32'(dm_be), 32'(q[0].be));
         chk("dm_pc", dm_pc, q[0].pc);
      end
      chk("fwd_mask", 32'(fwd_mask), 32'(e_mask));
      chk("fwd_data", fwd_data, e_fdata);
      chk("count", 32'(count), q.size());
      chk("empty", 32'(empty), 32'(q.size() == 0));
      @(posedge clk);
      if (!reset) begin
         q.delete();
      end else begin
         acc = e_ready && st_valid && ok;
         mrg = acc && (q.size() > 0) && (q[$].word == st_addr[31:2]) &&
               !((q.size() == 1) && e_we);
         if (e_we) void'(q.pop_front());
         if (acc) begin
            if (mrg) begin
               e = q[$];
               for (int unsigned l = 0; l < 4; l++) begin
                  if (nbe[l]) e.data[8*l +: 8] = ndata[8*l +: 8];
               end
               e.be = e.be | nbe;
               q[q.size()-1] = e;
            end else begin
               e.word = st_addr[31:2];
               e.data = ndata;
               e.be   = nbe;
               e.pc   = st_pc;
               q.push_back(e);
            end
         end
      end
      #1;
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_type  = t;
      st_pc    = 32'h1000 + a;
      step();
      st_valid = 1'b0;
   endtask

   initial begin
      reset    = 1'b0;
      st_valid = 1'b0;
      st_addr  = '0;
      st_data  = '0;
      st_type  = '0;
      st_pc    = '0;
      drain_en = 1'b0;
      ld_addr  = '0;
      repeat (2) @(posedge clk);
      #1;
      step();                       // reset values
      reset = 1'b1;
      #1 chk("ready_after_reset", 32'(st_ready), 32'd1);
      step();
      step();

      // Store sequence with drain_en=1
      drain_en = 1'b1;
      st(32'h10, 32'h12345678, 2'b00);
      #1;
      chk("sw_we", 32'(dm_we), 32'd1);
      chk("sw_addr", dm_addr, 32'h10);
      chk("sw_be", 32'(dm_be), 32'hF);
      chk("sw_data", dm_wdata, 32'h12345678);
      st(32'h13, 32'h000000AB, 2'b10);
      #1;
      chk("sb_be", 32'(dm_be), 32'h8);
      chk("sb_data", dm_wdata, 32'hAB000000);
      st(32'h16, 32'h0000BEEF, 2'b01);
      #1;
      chk("sh_be", 32'(dm_be), 32'hC);
      chk("sh_data", dm_wdata, 32'hBEEF0000);
      step();

      // Coalescing of two bytes into one entry
      drain_en = 1'b0;
      st(32'h20, 32'h00000011, 2'b10);
      st(32'h21, 32'h00000022, 2'b10);
      ld_addr = 32'h20;
      #1;
      chk("merge_count", 32'(count), 32'd1);
      chk("merge_mask", 32'(fwd_mask), 32'h3);
      chk("merge_fwd", fwd_data, 32'h00002211);
      step();
      drain_en = 1'b1;
      step();
      step();

      // Fill to DEPTH, then drain in order and refill across the wrap
      drain_en = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) st(32'h100 + 4*i, 32'hC0DE0000 + i, 2'b00);
      st(32'h110, 32'hDEADBEEF, 2'b00);   // refused while full
      chk("full_count", 32'(count), 32'd4);
      drain_en = 1'b1;
      step();
      chk("ready_after_pop", 32'(st_ready), 32'd1);
      st(32'h120, 32'h01020304, 2'b00);
      st(32'h124, 32'h05060708, 2'b00);
      repeat (6) step();

      // Youngest-wins forwarding across a separating entry
      drain_en = 1'b0;
      st(32'h40, 32'hAAAAAAAA, 2'b00);
      st(32'h44, 32'hBBBBBBBB, 2'b00);
      st(32'h40, 32'h00000055, 2'b10);
      ld_addr = 32'h40;
      #1;
      chk("yw_mask", 32'(fwd_mask), 32'hF);
      chk("yw_data", fwd_data, 32'hAAAAAA55);
      st_valid = 1'b1;
      st_addr  = 32'h41;
      st_type  = 2'b01;
      #1 chk("mis_flag", 32'(st_misalign), 32'd1);
      st(32'h41, 32'h00001234, 2'b01);
      chk("mis_count", 32'(count), 32'd3);

      // Reset with three entries pending and drain enabled
      drain_en = 1'b1;
      reset    = 1'b0;
      #1 chk("rst_no_we", 32'(dm_we), 32'd0);
      step();
      reset = 1'b1;
      #1 chk("rst_empty", 32'(empty), 32'd1);
      repeat (3) step();

      // Randomized traffic over a small address window
      for (int n = 0; n < 500; n++) begin
         reset    = ($urandom_range(0, 59) != 0);
         drain_en = ($urandom_range(0, 2) != 0);
         st_valid = ($urandom_range(0, 3) != 0);
         st_addr  = 32'h200 + $urandom_range(0, 15);
         st_data  = $urandom;
         st_type  = 2'($urandom_range(0, 3));
         st_pc    = $urandom;
         ld_addr  = 32'h200 + 4 * $urandom_range(0, 3);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-store queue between the MEM-stage store path and the data memory. Committed stores are turned into word-aligned, byte-enabled writes and held in a small FIFO. Entries drain to the data memory one per cycle whenever its write port is free. Loads in MEM get per-byte forwarding from pending entries, so stores can retire without waiting on the memory port.

## Interface
- DEPTH, 4, number of entries (power of two, ≥2)
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low (state cleared on a rising edge of clk while reset==0)
- st_valid  input  1  committed store request from MEM stage
- st_addr  input  32  byte address
- st_data  input  32  raw register value (payload in low bits)
- st_type  input  2  00 word, 01 half, 10 byte, 11 reserved (treated as misaligned)
- st_pc  input  32  PC of the store, carried to DM for trace
- st_ready  output  1  buffer can accept a store this cycle
- st_misalign  output  1  st_valid with an illegal alignment/type; store discarded
- drain_en  input  1  DM write port free this cycle
- dm_we  output  1  write to DM this cycle
- dm_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- dm_wdata  output  32  lane-positioned write data
- dm_be  output  4  byte enables, bit i = byte lane i (bits 8i+7:8i)
- dm_pc  output  32  PC of the oldest store in the drained entry
- ld_addr  input  32  load address in MEM, for forwarding lookup
- fwd_mask  output  4  byte lanes supplied by the buffer
- fwd_data  output  32  forwarded bytes (lanes with fwd_mask=0 are 0)
- empty  output  1  no pending entries
- count  output  $clog2(DEPTH)+1  pending entry count

## Operation
- Entry: valid, word address addr[31:2], data[31:0], be[3:0], pc. Circular FIFO with head/tail pointers plus count.
- Alignment: word needs addr[1:0]==00, half needs addr[0]==0, byte always legal. st_misalign = st_valid && illegal (combinational). No entry is written for an illegal store.
- Lane placement:
  - word: data=st_data, be=1111.
  - half: st_data[15:0] into lanes {addr[1],1} and {addr[1],0}, be=0011 or 1100.
  - byte: st_data[7:0] into lane addr[1:0], be one-hot.
  - Unused lanes are don't-care; zero them.
- st_ready = reset && (count < DEPTH). It does not depend on drain_en (no combinational path from the DM side).
- Accept when st_valid && st_ready && legal.
- Coalescing: merge the accepted store into the youngest entry when all of these hold:
  - the youngest entry exists;
  - its word address matches;
  - it is not the head being drained this cycle (that is, not count==1 && dm_we).
  - Merge rule: be |= new_be; each new lane overwrites its data byte; pc takes no update. count is unchanged.
  - Otherwise allocate at tail.
- Drain: dm_we = reset && !empty && drain_en. dm_addr, dm_wdata, dm_be and dm_pc come combinationally from the head entry. The head pops on the same edge.
- Simultaneous accept-allocate and drain: count unchanged, both pointers advance.
- Forwarding (combinational):
  - Compare ld_addr[31:2] with every valid entry, including the head being drained this cycle.
  - For each lane, select the youngest matching entry whose be bit is set.
  - A store being accepted in the same cycle is not visible.
- empty = (count==0).

## Timing
- Reset values: st_ready=0, dm_we=0, fwd_mask=0, fwd_data=0, empty=1, count=0, st_misalign=0. All entries are invalidated and pointers cleared.
- After reset deasserts, st_ready=1 in the first cycle.
- A store accepted at edge t is forwardable and drainable from cycle t+1. Minimum store-to-DM latency is 1 cycle.
- Full: st_ready=0 even if drain_en=1 in that cycle. st_ready rises the cycle after a pop.
- Pointer wrap: modulo DEPTH. count distinguishes full from empty.
- Reset mid-operation: pending entries are discarded with no DM write. dm_we is low in every cycle where reset==0.
- drain_en low: the head holds and dm_we=0. Outputs stay stable so the head is presented again.

## Test plan
- Reset then idle: empty=1, count=0, st_ready=1, dm_we=0.
- Store sequence with drain_en=1:
  - sw 0x12345678 @0x10 -> next cycle dm_we=1, dm_addr=0x10, dm_be=1111, dm_wdata=0x12345678.
  - sb 0xAB @0x13 -> dm_be=1000, dm_wdata[31:24]=0xAB.
  - sh 0xBEEF @0x16 -> dm_be=1100, dm_wdata[31:16]=0xBEEF.
- drain_en=0, then sb 0x11 @0x20 followed by sb 0x22 @0x21: one entry (count=1), be=0011, data[15:0]=0x2211. ld_addr=0x20 -> fwd_mask=0011, fwd_data=0x00002211.
- drain_en=0, fill DEPTH distinct words: st_ready drops at count=4. Raise drain_en: four writes in FIFO order, st_ready=1 the cycle after the first pop. Pointers wrap correctly on refill.
- Two entries for 0x40 separated by an entry for 0x44:
  - first sw 0xAAAAAAAA, later sb 0x55 @0x40 -> ld_addr=0x40 gives fwd_mask=1111, fwd_data=0xAAAAAA55.
  - sh @0x41 -> st_misalign=1, count unchanged.
- Three entries pending, drive reset=0 for one cycle with drain_en=1: dm_we=0 that cycle; afterwards empty=1 and no stale writes appear.
